read_clear_event_bank: RTL and testbench

Multi-channel, single-clock successor to the read-clear register, generalised to NUM_CHANNELS registers behind one processor read port. Each channel receives events from same-clock I/O logic and accumulates them in a per-channel mode: capture, sticky-OR or saturating count. A processor read returns the channel value and clears it under CLEAR_MASK without losing a same-cycle event. Per-channel pending and overflow flags and a combined interrupt request sit between the peripheral event sources and the processor I/O bus.

---
 rtl/read_clear_event_bank.sv | 155 +++++++++++++++
 tb/tb_read_clear_event_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/read_clear_event_bank.sv
// rtl/read_clear_event_bank.sv - multi-channel read-clear event registers with pending, overflow and irq
//
// Purpose: NUM_CHANNELS event registers behind one processor read port. Each
// channel accumulates events in capture, sticky-OR or saturating-count mode.
// A read returns the pre-clear value and clears the bits in CLEAR_MASK. An
// event in the same cycle as the read is applied on top of the cleared value,
// so it is never lost.
//
// Ports:
//   clk_i          - single clock, rising edge
//   rst_ni         - asynchronous active-low reset
//   rd_en_i        - processor read strobe
//   reg_select_i   - block select; a read happens on rd_en_i & reg_select_i
//   addr_i         - channel to read
//   rd_data_o      - registered read data, held between reads
//   rd_valid_o     - one-cycle pulse, rd_data_o updated
//   ev_valid_i     - per-channel event strobe
//   ev_data_i      - per-channel event data, channel i at [DW*(i+1)-1:DW*i]
//   irq_enable_i   - per-channel interrupt enable
//   pending_o      - channel holds an event not yet read
//   overflow_o     - sticky per-channel overflow
//   irq_req_o      - registered OR of pending & irq_enable
module read_clear_event_bank #(
    parameter int                          DATA_WIDTH   = 32,
    parameter int                          NUM_CHANNELS = 4,
    parameter int                          ADDR_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter logic [2*NUM_CHANNELS-1:0]   MODES        = '0,
    parameter logic [DATA_WIDTH-1:0]       RESET_VALUE  = '0,
    parameter logic [DATA_WIDTH-1:0]       CLEAR_MASK   = '1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               rd_en_i,
    input  logic                               reg_select_i,
    input  logic [ADDR_WIDTH-1:0]              addr_i,
    output logic [DATA_WIDTH-1:0]              rd_data_o,
    output logic                               rd_valid_o,
    input  logic [NUM_CHANNELS-1:0]            ev_valid_i,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ev_data_i,
    input  logic [NUM_CHANNELS-1:0]            irq_enable_i,
    output logic [NUM_CHANNELS-1:0]            pending_o,
    output logic [NUM_CHANNELS-1:0]            overflow_o,
    output logic                               irq_req_o
);

    localparam logic [1:0] MODE_STICKY = 2'd1;
    localparam logic [1:0] MODE_COUNT  = 2'd2;

    // Channel count widened by one bit so addresses at or above NUM_CHANNELS
    // compare correctly even when NUM_CHANNELS is a power of two.
    localparam logic [ADDR_WIDTH:0] NUM_CH_W = (ADDR_WIDTH + 1)'(NUM_CHANNELS);

    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ch_q, ch_d;
    logic [NUM_CHANNELS-1:0]                 pending_q, pending_d;
    logic [NUM_CHANNELS-1:0]                 overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]                   rd_data_q, rd_data_d;
    logic                                    rd_valid_q, rd_valid_d;
    logic                                    irq_q, irq_d;

    logic read_req;
    logic read_hit;

    assign read_req = rd_en_i & reg_select_i;
    assign read_hit = read_req & ({1'b0, addr_i} < NUM_CH_W);

    always_comb begin
        logic                  rd_this;
        logic [DATA_WIDTH-1:0] base;
        logic [DATA_WIDTH-1:0] ev;
        logic [DATA_WIDTH:0]   sum;

        ch_d       = ch_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = read_req;
        irq_d      = |(pending_q & irq_enable_i);
        rd_this    = 1'b0;
        base       = '0;
        ev         = '0;
        sum        = '0;

        // A read miss still returns data (zero) and pulses rd_valid.
        if (read_req) begin
            rd_data_d = '0;
        end

        for (int i = 0; i < NUM_CHANNELS; i++) begin
            rd_this = read_hit && (addr_i == ADDR_WIDTH'(i));
            base    = rd_this ? (ch_q[i] & ~CLEAR_MASK) : ch_q[i];
            ev      = ev_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            // Carry out of the extra bit marks a saturated counter.
            sum     = {1'b0, base} + (DATA_WIDTH + 1)'(1);

            if (rd_this) begin
                rd_data_d = ch_q[i];
            end

            ch_d[i]       = base;
            pending_d[i]  = pending_q[i] & ~rd_this;
            overflow_d[i] = overflow_q[i] & ~rd_this;

            // Event set wins over the same-cycle read clear.
            if (ev_valid_i[i]) begin
                pending_d[i] = 1'b1;
                case (MODES[2*i +: 2])
                    MODE_STICKY: begin
                        ch_d[i] = base | ev;
                    end
                    MODE_COUNT: begin
                        if (sum[DATA_WIDTH]) begin
                            ch_d[i]       = '1;
                            overflow_d[i] = 1'b1;
                        end else begin
                            ch_d[i] = sum[DATA_WIDTH-1:0];
                        end
                    end
                    default: begin
                        // Capture (and reserved): an unread capture being
                        // overwritten is the lost-event condition.
                        ch_d[i] = ev;
                        if (pending_q[i] && !rd_this) begin
                            overflow_d[i] = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ch_q       <= {NUM_CHANNELS{RESET_VALUE}};
            pending_q  <= '0;
            overflow_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ch_q       <= ch_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;
    assign irq_req_o  = irq_q;

endmodule

// File: tb/tb_read_clear_event_bank.sv
// tb/tb_read_clear_event_bank.sv - directed self-checking bench for read_clear_event_bank
module tb_read_clear_event_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 4 channels, ch3..ch0 = count, sticky, capture, capture, partial clear mask
    logic        a_rd_en, a_sel;
    logic [1:0]  a_addr;
    logic [7:0]  a_rd_data;
    logic        a_rd_valid;
    logic [3:0]  a_ev_valid;
    logic [31:0] a_ev_data;
    logic [3:0]  a_irq_en;
    logic [3:0]  a_pending, a_overflow;
    logic        a_irq;

    read_clear_event_bank #(
        .DATA_WIDTH   (8),
        .NUM_CHANNELS (4),
        .MODES        (8'b10_01_00_00),
        .RESET_VALUE  (8'h00),
        .CLEAR_MASK   (8'h0F)
    ) dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rd_en_i      (a_rd_en),
        .reg_select_i (a_sel),
        .addr_i       (a_addr),
        .rd_data_o    (a_rd_data),
        .rd_valid_o   (a_rd_valid),
        .ev_valid_i   (a_ev_valid),
        .ev_data_i    (a_ev_data),
        .irq_enable_i (a_irq_en),
        .pending_o    (a_pending),
        .overflow_o   (a_overflow),
        .irq_req_o    (a_irq)
    );

    // DUT B: 3 channels, all capture, full clear mask (read-miss checks)
    logic        b_rd_en, b_sel;
    logic [1:0]  b_addr;
    logic [7:0]  b_rd_data;
    logic        b_rd_valid;
    logic [2:0]  b_ev_valid;
    logic [23:0] b_ev_data;
    logic [2:0]  b_irq_en;
    logic [2:0]  b_pending, b_overflow;
    logic        b_irq;

    read_clear_event_bank #(
        .DATA_WIDTH   (8),
        .NUM_CHANNELS (3)
    ) dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rd_en_i      (b_rd_en),
        .reg_select_i (b_sel),
        .addr_i       (b_addr),
        .rd_data_o    (b_rd_data),
        .rd_valid_o   (b_rd_valid),
        .ev_valid_i   (b_ev_valid),
        .ev_data_i    (b_ev_data),
        .irq_enable_i (b_irq_en),
        .pending_o    (b_pending),
        .overflow_o   (b_overflow),
        .irq_req_o    (b_irq)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_read(input logic [1:0] addr);
        a_rd_en = 1'b1;
        a_sel   = 1'b1;
        a_addr  = addr;
        cyc();
        a_rd_en = 1'b0;
        a_sel   = 1'b0;
    endtask

    task automatic b_read(input logic [1:0] addr);
        b_rd_en = 1'b1;
        b_sel   = 1'b1;
        b_addr  = addr;
        cyc();
        b_rd_en = 1'b0;
        b_sel   = 1'b0;
    endtask

    task automatic a_event(input logic [3:0] valid, input logic [31:0] data);
        a_ev_valid = valid;
        a_ev_data  = data;
        cyc();
        a_ev_valid = '0;
        a_ev_data  = '0;
    endtask

    initial begin
        a_rd_en = 0; a_sel = 0; a_addr = 0; a_ev_valid = 0; a_ev_data = 0; a_irq_en = 0;
        b_rd_en = 0; b_sel = 0; b_addr = 0; b_ev_valid = 0; b_ev_data = 0; b_irq_en = 0;

        // Reset and idle
        rst_n = 1'b0;
        cyc();
        cyc();
        check_eq("rst_rd_data",  a_rd_data,  8'h00);
        check_eq("rst_rd_valid", a_rd_valid, 1'b0);
        check_eq("rst_pending",  a_pending,  4'h0);
        check_eq("rst_overflow", a_overflow, 4'h0);
        check_eq("rst_irq",      a_irq,      1'b0);
        rst_n = 1'b1;
        cyc();

        a_read(2'd0);
        check_eq("idle_rd_data",  a_rd_data,  8'h00);
        check_eq("idle_rd_valid", a_rd_valid, 1'b1);
        cyc();
        check_eq("idle_rd_valid_drop", a_rd_valid, 1'b0);

        // Capture overflow on ch0
        a_event(4'b0001, 32'h0000_0011);
        check_eq("cap_pending1",  a_pending,  4'b0001);
        check_eq("cap_overflow1", a_overflow, 4'b0000);
        a_event(4'b0001, 32'h0000_0022);
        check_eq("cap_overflow2", a_overflow, 4'b0001);
        a_read(2'd0);
        check_eq("cap_rd_data",  a_rd_data,  8'h22);
        check_eq("cap_pending0", a_pending,  4'b0000);
        check_eq("cap_ovf_clr",  a_overflow, 4'b0000);

        // Sticky-OR on ch2 with a same-cycle event during the read
        a_event(4'b0100, 32'h0001_0000);
        a_event(4'b0100, 32'h0004_0000);
        a_ev_valid = 4'b0100;
        a_ev_data  = 32'h0080_0000;
        a_read(2'd2);
        a_ev_valid = '0;
        a_ev_data  = '0;
        check_eq("sticky_rd_data", a_rd_data, 8'h05);
        check_eq("sticky_pending", a_pending, 4'b0100);
        a_read(2'd2);
        check_eq("sticky_rd_after", a_rd_data, 8'h80);
        check_eq("sticky_pend_clr", a_pending, 4'b0000);

        // Count saturation on ch3 with partial clear mask
        a_ev_valid = 4'b1000;
        for (int k = 0; k < 300; k++) cyc();
        a_ev_valid = '0;
        check_eq("cnt_overflow", a_overflow, 4'b1000);
        check_eq("cnt_pending",  a_pending,  4'b1000);
        a_read(2'd3);
        check_eq("cnt_rd_data",  a_rd_data,  8'hFF);
        check_eq("cnt_ovf_clr",  a_overflow, 4'b0000);
        a_read(2'd3);
        check_eq("cnt_masked",   a_rd_data,  8'hF0);

        // Interrupt on ch2 only
        a_irq_en = 4'b0100;
        a_event(4'b0100, 32'h0002_0000);
        check_eq("irq_edge1", a_irq, 1'b0);
        cyc();
        check_eq("irq_edge2", a_irq, 1'b1);
        a_read(2'd2);
        check_eq("irq_rd_edge1", a_irq, 1'b1);
        cyc();
        check_eq("irq_rd_edge2", a_irq, 1'b0);
        a_event(4'b0010, 32'h0000_3300);
        cyc();
        check_eq("irq_ch1_pend", a_pending, 4'b0010);
        check_eq("irq_ch1_none", a_irq, 1'b0);

        // Read miss on the 3-channel instance
        b_ev_valid = 3'b001;
        b_ev_data  = 24'h00005A;
        cyc();
        b_ev_valid = '0;
        b_ev_data  = '0;
        b_read(2'd3);
        check_eq("miss_rd_data",  b_rd_data,  8'h00);
        check_eq("miss_rd_valid", b_rd_valid, 1'b1);
        check_eq("miss_pending",  b_pending,  3'b001);
        b_read(2'd0);
        check_eq("miss_ch0_data", b_rd_data,  8'h5A);
        b_read(2'd3);
        check_eq("miss_zero",     b_rd_data,  8'h00);

        // Reset the cycle after a read strobe
        a_read(2'd0);
        check_eq("mid_rd_valid_pre", a_rd_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rd_valid", a_rd_valid, 1'b0);
        check_eq("mid_pending",  a_pending,  4'b0000);
        cyc();
        rst_n = 1'b1;
        cyc();
        a_read(2'd3);
        check_eq("mid_ch3", a_rd_data, 8'h00);
        a_read(2'd2);
        check_eq("mid_ch2", a_rd_data, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
